// File: rtl/scaler2_tpg.sv
// Test-pattern generator feeding a 2D scaler. Emits one frame of width x height
// pixels in raster order on a valid/ready stream with sof/eol/eof markers.
// Patterns: zero, delta pulse on the centre row, horizontal ramp, centre cross.
module scaler2_tpg #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 12
) (
    input  logic          p_in_clk,
    input  logic          p_in_rst,
    input  logic          p_in_start,
    input  logic [CW-1:0] p_in_width,
    input  logic [CW-1:0] p_in_height,
    input  logic [1:0]    p_in_mode,
    input  logic          p_in_ready,
    output logic [DW-1:0] p_out_data,
    output logic          p_out_valid,
    output logic          p_out_sof,
    output logic          p_out_eol,
    output logic          p_out_eof,
    output logic          p_out_busy,
    output logic          p_out_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] w_q, w_d, h_q, h_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          xfer;
    logic [CW-1:0] nx, ny;

    // Pixel value at (x, y) for the given pattern and frame centre.
    function automatic logic [DW-1:0] pattern(
        input logic [1:0]    mode,
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy
    );
        logic [CW-1:0] dx;
        logic [7:0]    v8;
        logic [DW-1:0] pix;
        dx  = (x >= cx) ? (x - cx) : (cx - x);
        v8  = 8'd0;
        pix = '0;
        case (mode)
            2'd1: begin
                if (y == cy) begin
                    if (dx == CW'(0))      v8 = 8'd255;
                    else if (dx == CW'(1)) v8 = 8'd192;
                    else if (dx == CW'(2)) v8 = 8'd100;
                    else if (dx == CW'(3)) v8 = 8'd32;
                end
                // The 8-bit pulse table is truncated for narrow pixels.
                pix = DW'(v8);
            end
            2'd2:    pix = DW'(x);
            2'd3:    pix = ((x == cx) || (y == cy)) ? '1 : '0;
            default: pix = '0;
        endcase
        return pix;
    endfunction

    // Next-state: frame sequencing and the registered pixel stream.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        mode_d  = mode_q;
        data_d  = data_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = (state_q == StDone);
        nx      = '0;
        ny      = '0;
        xfer    = valid_q & p_in_ready;

        case (state_q)
            StIdle: begin
                if (p_in_start) begin
                    w_d    = p_in_width;
                    h_d    = p_in_height;
                    mode_d = p_in_mode;
                    cx_d   = p_in_width >> 1;
                    cy_d   = p_in_height >> 1;
                    x_d    = '0;
                    y_d    = '0;
                    if ((p_in_width != '0) && (p_in_height != '0)) begin
                        // First pixel is registered on the accepting edge.
                        state_d = StRun;
                        valid_d = 1'b1;
                        sof_d   = 1'b1;
                        eol_d   = (p_in_width == CW'(1));
                        eof_d   = (p_in_width == CW'(1)) && (p_in_height == CW'(1));
                        data_d  = pattern(p_in_mode, '0, '0, p_in_width >> 1,
                                          p_in_height >> 1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    if (eof_q) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        sof_d   = 1'b0;
                        eol_d   = 1'b0;
                        eof_d   = 1'b0;
                        data_d  = '0;
                    end else begin
                        if (eol_q) begin
                            nx = '0;
                            ny = y_q + CW'(1);
                        end else begin
                            nx = x_q + CW'(1);
                            ny = y_q;
                        end
                        x_d     = nx;
                        y_d     = ny;
                        valid_d = 1'b1;
                        sof_d   = 1'b0;
                        eol_d   = (nx == w_q - CW'(1));
                        eof_d   = (nx == w_q - CW'(1)) && (ny == h_q - CW'(1));
                        data_d  = pattern(mode_q, nx, ny, cx_q, cy_q);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge p_in_clk or posedge p_in_rst) begin
        if (p_in_rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign p_out_data  = data_q;
    assign p_out_valid = valid_q;
    assign p_out_sof   = sof_q;
    assign p_out_eol   = eol_q;
    assign p_out_eof   = eof_q;
    assign p_out_busy  = busy_q;
    assign p_out_done  = done_q;

endmodule

// File: tb/tb_scaler2_tpg.sv
// Bench for scaler2_tpg: a frame-level reference model (queue of expected
// pixels built from the pattern formulas) checked every cycle, plus directed
// frames with hand-computed literal expectations.
module tb_scaler2_tpg;

    localparam int DW = 8;
    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] width;
    logic [CW-1:0] height;
    logic [1:0]    mode;
    logic          ready;
    logic [DW-1:0] data;
    logic          valid;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          done;

    typedef struct {
        int data;
        bit sof;
        bit eol;
        bit eof;
    } pix_t;

    pix_t exp_q[$];
    pix_t log_q[$];
    bit   done_pending;
    bit   exp_done;
    bit   ev;
    bit   exp_valid;
    int   done_cnt;
    int   errors;
    int   checks;

    scaler2_tpg #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .p_in_clk   (clk),
        .p_in_rst   (rst),
        .p_in_start (start),
        .p_in_width (width),
        .p_in_height(height),
        .p_in_mode  (mode),
        .p_in_ready (ready),
        .p_out_data (data),
        .p_out_valid(valid),
        .p_out_sof  (sof),
        .p_out_eol  (eol),
        .p_out_eof  (eof),
        .p_out_busy (busy),
        .p_out_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pattern value straight from the pattern definitions.
    function automatic int exp_pix(input int m, input int x, input int y, input int w,
                                   input int h);
        int cx, cy, dx, r;
        cx = w / 2;
        cy = h / 2;
        dx = (x > cx) ? x - cx : cx - x;
        r  = 0;
        if (m == 1 && y == cy) begin
            if (dx == 0)      r = 255;
            else if (dx == 1) r = 192;
            else if (dx == 2) r = 100;
            else if (dx == 3) r = 32;
        end else if (m == 2) begin
            r = x % 256;
        end else if (m == 3) begin
            r = (x == cx || y == cy) ? 255 : 0;
        end
        return r;
    endfunction

    // Reference model: frame-level view of the stream, advanced on each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            done_pending = 1'b0;
            exp_done     = 1'b0;
        end else begin
            ev = 1'b0;
            if (exp_q.size() > 0) begin
                if (ready) begin
                    if (exp_q[0].eof) ev = 1'b1;
                    void'(exp_q.pop_front());
                end
            end else if (!done_pending && start) begin
                if (width == 0 || height == 0) begin
                    ev = 1'b1;
                end else begin
                    for (int yy = 0; yy < int'(height); yy++) begin
                        for (int xx = 0; xx < int'(width); xx++) begin
                            pix_t p;
                            p.data = exp_pix(int'(mode), xx, yy, int'(width), int'(height));
                            p.sof  = (xx == 0 && yy == 0);
                            p.eol  = (xx == int'(width) - 1);
                            p.eof  = (xx == int'(width) - 1) && (yy == int'(height) - 1);
                            exp_q.push_back(p);
                        end
                    end
                end
            end
            exp_done     = done_pending;
            done_pending = ev;
        end
    end

    // Compare DUT against the model mid-cycle; log accepted pixels.
    always @(negedge clk) begin
        if (!rst) begin
            exp_valid = (exp_q.size() > 0);
            check("valid", int'(valid), int'(exp_valid));
            check("busy", int'(busy), int'(exp_valid));
            check("done", int'(done), int'(exp_done));
            if (exp_valid && valid) begin
                check("data", int'(data), exp_q[0].data);
                check("sof", int'(sof), int'(exp_q[0].sof));
                check("eol", int'(eol), int'(exp_q[0].eol));
                check("eof", int'(eof), int'(exp_q[0].eof));
            end
            if (valid && ready) begin
                pix_t p;
                p.data = int'(data);
                p.sof  = sof;
                p.eol  = eol;
                p.eof  = eof;
                log_q.push_back(p);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int w, input int h, input int m);
        width  = CW'(w);
        height = CW'(h);
        mode   = 2'(m);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Run until the next done pulse; bp applies the 1,0,0,1 ready pattern.
    task automatic wait_done(input int budget, input bit bp);
        int n0;
        int i;
        n0 = done_cnt;
        i  = 0;
        while (done_cnt == n0 && i < budget) begin
            if (bp) ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
            i++;
        end
        ready = 1'b1;
        if (done_cnt == n0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n0;
        int i;
        int eols;
        errors = 0;
        checks = 0;
        done_cnt = 0;
        rst    = 1'b1;
        start  = 1'b0;
        width  = '0;
        height = '0;
        mode   = '0;
        ready  = 1'b1;
        repeat (3) tick();
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Delta pulse 25x25, start on the first edge after reset release.
        rst = 1'b0;
        log_q.delete();
        start_frame(25, 25, 1);
        check("first_valid", int'(valid), 1);
        check("first_sof", int'(sof), 1);
        wait_done(2000, 1'b0);
        check("delta_count", log_q.size(), 625);
        if (log_q.size() == 625) begin
            check("delta_r12_x12", log_q[12 * 25 + 12].data, 255);
            check("delta_r12_x11", log_q[12 * 25 + 11].data, 192);
            check("delta_r12_x14", log_q[12 * 25 + 14].data, 100);
            check("delta_r12_x9", log_q[12 * 25 + 9].data, 32);
            check("delta_r12_x8", log_q[12 * 25 + 8].data, 0);
            check("delta_r11_x12", log_q[11 * 25 + 12].data, 0);
            check("delta_sof0", int'(log_q[0].sof), 1);
            check("delta_eol24", int'(log_q[24].eol), 1);
            check("delta_eof624", int'(log_q[624].eof), 1);
            eols = 0;
            foreach (log_q[k]) if (log_q[k].eol) eols++;
            check("delta_eols", eols, 25);
        end

        // Ramp 8x2 under backpressure.
        log_q.delete();
        start_frame(8, 2, 2);
        wait_done(200, 1'b1);
        check("ramp_count", log_q.size(), 16);
        if (log_q.size() == 16) begin
            check("ramp_0", log_q[0].data, 0);
            check("ramp_7", log_q[7].data, 7);
            check("ramp_8", log_q[8].data, 0);
            check("ramp_15", log_q[15].data, 7);
        end

        // Cross 5x4, with a start during RUN that must be ignored.
        log_q.delete();
        start_frame(5, 4, 3);
        tick();
        start_frame(7, 3, 2);
        wait_done(200, 1'b0);
        check("cross_count", log_q.size(), 20);
        if (log_q.size() == 20) begin
            check("cross_r0_x2", log_q[2].data, 255);
            check("cross_r0_x0", log_q[0].data, 0);
            check("cross_r2_x0", log_q[10].data, 255);
            check("cross_r2_x4", log_q[14].data, 255);
            check("cross_r3_x4", log_q[19].data, 0);
        end
        repeat (3) tick();

        // Zero-size frame: done two edges after start, never valid or busy.
        log_q.delete();
        n0 = done_cnt;
        start_frame(0, 5, 1);
        check("zero_done_early", int'(done), 0);
        check("zero_busy", int'(busy), 0);
        tick();
        check("zero_done", int'(done), 1);
        tick();
        check("zero_done_once", done_cnt - n0, 1);
        check("zero_count", log_q.size(), 0);

        // 1x1 delta frame.
        log_q.delete();
        start_frame(1, 1, 1);
        wait_done(50, 1'b0);
        check("one_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("one_data", log_q[0].data, 255);
            check("one_marks", {29'd0, log_q[0].sof, log_q[0].eol, log_q[0].eof}, 7);
        end

        // Reset at transfer 100, then a full restart.
        log_q.delete();
        start_frame(25, 25, 2);
        i = 0;
        while (log_q.size() < 100 && i < 500) begin
            tick();
            i++;
        end
        check("mid_reached", log_q.size(), 100);
        n0  = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sof", int'(sof), 0);
        check("mid_rst_eol", int'(eol), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("mid_no_done", done_cnt - n0, 0);
        log_q.delete();
        start_frame(25, 25, 1);
        wait_done(2000, 1'b0);
        check("restart_count", log_q.size(), 625);
        check("restart_done", done_cnt - n0, 1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scaler2_tpg.md
SCALER2_TPG -- requirements
Module: scaler2_tpg

Interface
REQ-001 Parameter DW, default 8: pixel data width in bits.
REQ-002 Parameter CW, default 12: width of the frame-size and coordinate counters.
REQ-003 p_in_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 p_in_rst  input  1  reset, asynchronous and active-high.
REQ-005 p_in_start  input  1  frame request; a one-cycle pulse, honoured only in IDLE.
REQ-006 p_in_width  input  CW  frame width in pixels; sampled on an accepted start.
REQ-007 p_in_height  input  CW  frame height in lines; sampled on an accepted start.
REQ-008 p_in_mode  input  2  pattern select (0 zero, 1 delta pulse, 2 ramp, 3 cross); sampled on an accepted start.
REQ-009 p_in_ready  input  1  downstream (scaler) ready to accept a pixel.
REQ-010 p_out_data  output  DW  pixel value.
REQ-011 p_out_valid  output  1  p_out_data is valid.
REQ-012 p_out_sof  output  1  first pixel of the frame, qualified by p_out_valid.
REQ-013 p_out_eol  output  1  last pixel of a line, qualified by p_out_valid.
REQ-014 p_out_eof  output  1  last pixel of the frame, qualified by p_out_valid.
REQ-015 p_out_busy  output  1  high while the FSM is in RUN.
REQ-016 p_out_done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start when width!=0 and height!=0.
- IDLE->DONE on start when width==0 or height==0.
- RUN->DONE on the transfer of the eof pixel.
- DONE->IDLE unconditionally after 1 cycle.
REQ-018 A transfer occurs when p_out_valid=1 and p_in_ready=1 in the same cycle; x and y advance only on a transfer.
REQ-019 Transfer sequencing:
- x increments from 0 to width-1, then wraps to 0 and y increments.
- After x=width-1 and y=height-1, no further pixel is generated.
REQ-020 All outputs are registered.
- First valid pixel (x=0, y=0) appears on the cycle after the start edge.
- Sustained throughput is 1 pixel/clock while p_in_ready=1.
REQ-021 While p_out_valid=1 and p_in_ready=0: data, sof, eol, eof and valid hold stable; valid never drops without a transfer.
REQ-022 p_in_start asserted during RUN or DONE is ignored; there is no queuing.
REQ-023 Frame centre: cx=floor(width/2), cy=floor(height/2), computed at start.
REQ-024 Mode 1 (delta pulse), on row y=cy only: dx=|x-cx| gives 255 for dx=0, 192 for dx=1, 100 for dx=2, 32 for dx=3; every other pixel is 0.
REQ-025 Mode 2 (ramp): data = x[DW-1:0], wrapping modulo 2^DW.
REQ-026 Mode 3 (cross): data = 2^DW-1 where x==cx or y==cy, else 0.
REQ-027 Mode 0: data = 0 for every pixel.
REQ-028 Pattern values are truncated to DW bits when DW<8.
REQ-029 Marker rules for a 1-pixel frame (1x1): sof, eol and eof all assert on the same pixel.
REQ-030 p_out_eol asserts together with p_out_eof on the final pixel.
REQ-031 p_out_done pulses exactly once per accepted start, including zero-size starts; busy stays 0 for zero-size frames.

Reset
REQ-032 Reset takes effect asynchronously and forces:
- FSM to IDLE;
- x, y, cx, cy and the mode register to 0;
- all outputs to 0.
REQ-033 Reset during RUN abandons the frame: no eof and no done are generated; after release the block waits in IDLE for a new start.
REQ-034 The first start is accepted on the first rising clock edge after reset deasserts.

Verification
REQ-035 Delta pulse frame: mode=1, 25x25, ready=1.
- 625 transfers.
- Row 12 is ...0,32,100,192,255,192,100,32,0...; the 255 is at x=12.
- Every other row is all 0.
- sof on transfer 0, eol every 25th transfer, eof plus done after transfer 624.
REQ-036 Backpressure: mode=2, 8x2, ready toggled 1,0,0,1,...
- Data sequence is 0..7,0..7, with no loss or duplication.
- Outputs remain stable while ready=0.
REQ-037 Cross frame: mode=3, 5x4 (cx=2, cy=2).
- Row 2 is all 255.
- Other rows are 0,0,255,0,0.
REQ-038 Zero size: width=0, height=5, start.
- No valid is ever asserted.
- busy stays 0.
- done pulses 2 cycles after start.
REQ-039 1x1 frame, mode=1: a single transfer with data=255 and sof=eol=eof=1, then done.
REQ-040 Reset mid-frame, then restart.
- Assert reset at transfer 100 of a 25x25 frame: outputs are 0 immediately and no done is generated.
- A new start after release produces a full 625-pixel frame.
